mdu_seq_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit, parametrised in width. Decodes Funct3 for
//   R-type ops with Funct7=0000001 and computes the result over multiple cycles.
//   It sits beside the ALU in EX and stalls the pipeline while busy.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_div_core.sv | 49 ++++
 rtl/mdu_seq_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_seq_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: Funct3 op codes,
// decode constants, FSM states and operand-signedness helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

  // MUL is treated as signed x signed; its low half is identical either way.
  function automatic logic op_a_signed(input mdu_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division datapath on unsigned magnitudes: one quotient bit per step.
// Exposes the post-step quotient/remainder so the caller can latch the final step.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quot_next_o,
  output logic [DATA_W-1:0] rem_next_o
);

  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_divisor;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_fits;

  // The dividend shifts out of the quotient register MSB-first into the remainder.
  assign w_shift = {r_rem, r_quot[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_fits  = ~w_diff[DATA_W];

  assign quot_next_o = {r_quot[DATA_W-2:0], w_fits};
  assign rem_next_o  = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (load_i) begin
      r_quot    <= dividend_i;
      r_rem     <= '0;
      r_divisor <= divisor_i;
    end else if (step_i) begin
      r_quot    <= quot_next_o;
      r_rem     <= rem_next_o;
    end
  end

endmodule

// File: rtl/mdu_seq_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake and flush.
// Define MDU_FAST_MUL_EN to compute all multiplies in one cycle at accept.
module mdu_seq_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        Funct7,
  input  logic [2:0]        Funct3,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  mdu_state_e          r_state;
  mdu_state_e          w_state_next;
  mdu_op_e             r_op;
  mdu_op_e             w_op;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic                r_rem_neg;
  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_result;

  logic                w_accept;
  logic                w_is_div;
  logic                w_sa;
  logic                w_sb;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [DATA_W-1:0]   w_special_res;
  logic                w_early_done;
  logic [DATA_W-1:0]   w_early_res;
  logic                w_last_step;
  logic                w_busy;
  logic                w_done;

  logic [2*DATA_W-1:0] w_prod_step;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_mul_res;
  logic [DATA_W-1:0]   w_quot_next;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_div_res;

  // ---------------- accept-time decode ----------------
  assign w_op     = mdu_op_e'(Funct3);
  assign w_is_div = op_is_div(w_op);
  assign w_accept = (r_state == IDLE) && start_i && !flush_i &&
                    (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);

  assign w_sa    = op_a_signed(w_op) & a_i[DATA_W-1];
  assign w_sb    = op_b_signed(w_op) & b_i[DATA_W-1];
  assign w_abs_a = w_sa ? (~a_i + 1'b1) : a_i;
  assign w_abs_b = w_sb ? (~b_i + 1'b1) : b_i;

  assign w_div_zero = (b_i == '0);
  assign w_div_ovf  = ((w_op == DIV) || (w_op == REM)) && (a_i == MIN_VAL) && (b_i == '1);
  assign w_special  = w_is_div && (w_div_zero || w_div_ovf);

  // Funct3[1] separates the remainder ops from the quotient ops.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = Funct3[1] ? a_i : '1;
    end else begin
      w_special_res = Funct3[1] ? '0 : MIN_VAL;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [DATA_W:0]     w_fast_a;
  logic signed [DATA_W:0]     w_fast_b;
  logic signed [2*DATA_W-1:0] w_fast_prod;

  assign w_fast_a     = {w_sa, a_i};
  assign w_fast_b     = {w_sb, b_i};
  assign w_fast_prod  = w_fast_a * w_fast_b;
  assign w_early_done = w_special || !w_is_div;
  assign w_early_res  = w_is_div      ? w_special_res :
                        (w_op == MUL) ? w_fast_prod[DATA_W-1:0] :
                                        w_fast_prod[2*DATA_W-1:DATA_W];
`else
  assign w_early_done = w_special;
  assign w_early_res  = w_special_res;
`endif

  // ---------------- iterative datapath ----------------
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_fix  = r_neg ? (~w_prod_step + 1'b1) : w_prod_step;
  assign w_mul_res   = (r_op == MUL) ? w_prod_fix[DATA_W-1:0] : w_prod_fix[2*DATA_W-1:DATA_W];

  mdu_div_core #(
    .DATA_W (DATA_W)
  ) u_div_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (w_accept && w_is_div && !w_special),
    .step_i      ((r_state == BUSY) && op_is_div(r_op) && !flush_i),
    .dividend_i  (w_abs_a),
    .divisor_i   (w_abs_b),
    .quot_next_o (w_quot_next),
    .rem_next_o  (w_rem_next)
  );

  always_comb begin
    w_div_res = '0;
    if ((r_op == REM) || (r_op == REMU)) begin
      w_div_res = r_rem_neg ? (~w_rem_next + 1'b1) : w_rem_next;
    end else begin
      w_div_res = r_neg ? (~w_quot_next + 1'b1) : w_quot_next;
    end
  end

  assign w_last_step = (r_cnt == CNT_W'(1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_early_done ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (w_last_step) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = !flush_i;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // A flush wins over every transition, including a same-cycle accept.
    if (flush_i) begin
      w_state_next = IDLE;
    end
  end

  // ---------------- operand / result registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= MUL;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_mplier  <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_cnt     <= CNT_W'(DATA_W);
      r_neg     <= w_sa ^ w_sb;
      r_rem_neg <= w_sa;
      r_mcand   <= {{DATA_W{1'b0}}, w_abs_a};
      r_prod    <= '0;
      r_mplier  <= w_abs_b;
      if (w_early_done) begin
        r_result <= w_early_res;
      end
    end else if ((r_state == BUSY) && !flush_i) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_step;
      if (w_last_step) begin
        r_result <= op_is_div(r_op) ? w_div_res : w_mul_res;
      end
    end
  end

  assign result_o = r_result;
  assign busy_o   = w_busy;
  assign done_o   = w_done;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Scoreboard bench for mdu_seq_unit: 32-bit and 16-bit instances, reference model
// built from native 64-bit arithmetic, latency/busy/flush/reset/decode checks.
`timescale 1ns/1ps
module tb_mdu_seq_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ALUOp = 2'b00;
  logic [6:0]  Funct7 = 7'b0;
  logic [2:0]  Funct3 = 3'b0;
  logic        flush = 1'b0;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic        busy32, done32, busy16, done16;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done32_cnt = 0;
  int          done16_cnt = 0;
  logic [31:0] q32[$];
  logic [31:0] q16[$];
  logic [31:0] mon_exp32, mon_exp16;

  always #5 clk = ~clk;

  mdu_seq_unit #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset(reset), .start_i(start32), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .flush_i(flush), .a_i(a32), .b_i(b32),
    .result_o(res32), .busy_o(busy32), .done_o(done32)
  );

  mdu_seq_unit #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .start_i(start16), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .flush_i(flush), .a_i(a16), .b_i(b16),
    .result_o(res16), .busy_o(busy16), .done_o(done16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input int w, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, p, r;
    longint      ua, ub, sa, sb, smin;
    m    = (64'd1 << w) - 64'd1;
    ua   = longint'({32'd0, a} & m);
    ub   = longint'({32'd0, b} & m);
    sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
    sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
    smin = -(longint'(1) << (w - 1));
    r    = '0;
    case (f3)
      F_MUL:    begin p = 64'(sa * sb); r = p & m; end
      F_MULH:   begin p = 64'(sa * sb); r = (p >> w) & m; end
      F_MULHSU: begin p = 64'(sa * ub); r = (p >> w) & m; end
      F_MULHU:  begin p = 64'(ua * ub); r = (p >> w) & m; end
      F_DIV:    r = (ub == 0) ? m : (sa == smin && sb == -1) ? 64'(smin) & m : 64'(sa / sb) & m;
      F_DIVU:   r = (ub == 0) ? m : 64'(ua / ub);
      F_REM:    r = (ub == 0) ? 64'(ua) : (sa == smin && sb == -1) ? 64'd0 : 64'(sa % sb) & m;
      default:  r = (ub == 0) ? 64'(ua) : 64'(ua % ub);
    endcase
    return r[31:0];
  endfunction

  function automatic int mul_lat32();
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic int lat32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return mul_lat32();
    if (b == 32'd0) return 1;
    if ((f3 == F_DIV || f3 == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Scoreboard side: every done_o pops one expected result.
  always @(negedge clk) begin
    if (!reset && done32 === 1'b1) begin
      done32_cnt++;
      if (q32.size() == 0) check_eq("spurious_done32", 32'd1, 32'd0);
      else begin
        mon_exp32 = q32.pop_front();
        check_eq("result32", res32, mon_exp32);
      end
    end
    if (!reset && done16 === 1'b1) begin
      done16_cnt++;
      if (q16.size() == 0) check_eq("spurious_done16", 32'd1, 32'd0);
      else begin
        mon_exp16 = q16.pop_front();
        check_eq("result16", {16'd0, res16}, mon_exp16);
      end
    end
  end

  // Holds start_i until done_o, as the pipeline would.
  task automatic run_op(input bit w16, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat);
    int lat, busy_n;
    logic bz, dn;
    lat = 0;
    busy_n = 0;
    if (w16) q16.push_back(ref_op(16, f3, a, b));
    else     q32.push_back(ref_op(32, f3, a, b));
    Funct3 = f3;
    ALUOp  = 2'b10;
    Funct7 = 7'b0000001;
    if (w16) begin a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
    else     begin a32 = a;       b32 = b;       start32 = 1'b1; end
    @(negedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bz = w16 ? busy16 : busy32;
      dn = w16 ? done16 : done32;
      if (bz) busy_n++;
      if (dn) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
    $display("op w=%0d f3=%0d a=%h b=%h res=%h lat=%0d", w16 ? 16 : 32, f3, a, b,
             w16 ? {16'd0, res16} : res32, lat);
    @(posedge clk); #1;
    start32 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic try_bad(input logic [1:0] aluop, input logic [6:0] f7);
    int busy_n, d0;
    busy_n = 0;
    d0 = done32_cnt;
    ALUOp = aluop; Funct7 = f7; Funct3 = F_DIVU; a32 = 32'd50; b32 = 32'd5;
    start32 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy32) busy_n++;
    end
    check_eq("bad_decode_busy", 32'(busy_n), 32'd0);
    check_eq("bad_decode_done", 32'(done32_cnt - d0), 32'd0);
    $display("bad decode ALUOp=%b Funct7=%b busy_cycles=%0d", aluop, f7, busy_n);
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  initial begin
    int d0;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_result32", res32, 32'd0);
    check_eq("rst_busy32", {31'd0, busy32}, 32'd0);
    check_eq("rst_done32", {31'd0, done32}, 32'd0);
    check_eq("rst_result16", {16'd0, res16}, 32'd0);
    check_eq("rst_busy16", {31'd0, busy16}, 32'd0);
    @(posedge clk); #1;

    run_op(0, F_MUL,    32'd7,          32'hFFFF_FFFD, mul_lat32());
    run_op(0, F_MULH,   32'h8000_0000,  32'h8000_0000, mul_lat32());
    run_op(0, F_MULHU,  32'h8000_0000,  32'h8000_0000, mul_lat32());
    run_op(0, F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, mul_lat32());
    run_op(0, F_DIV,    32'hFFFF_FFF9,  32'd2,         33);
    run_op(0, F_REM,    32'hFFFF_FFF9,  32'd2,         33);
    run_op(0, F_DIVU,   32'd100,        32'd7,         33);
    run_op(0, F_REMU,   32'd100,        32'd7,         33);
    repeat (3) @(negedge clk);
    check_eq("result_hold", res32, 32'd2);
    @(posedge clk); #1;

    run_op(0, F_DIV,    32'd5,          32'd0,         1);
    run_op(0, F_REM,    32'd5,          32'd0,         1);
    run_op(0, F_DIVU,   32'd5,          32'd0,         1);
    run_op(0, F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1);
    run_op(0, F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1);

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(7, 0));
      ra = $urandom;
      rb = (i == 3) ? 32'd3 : $urandom;
      run_op(0, rf, ra, rb, lat32(rf, ra, rb));
    end

    // Flush a multiply mid-flight, then accept a new op on the very next cycle.
    d0 = done32_cnt;
    Funct3 = F_MUL; ALUOp = 2'b10; Funct7 = 7'b0000001;
    a32 = 32'd7; b32 = 32'hFFFF_FFFD; start32 = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_idle_busy", {31'd0, busy32}, 32'd0);
    check_eq("flush_no_done", 32'(done32_cnt - d0), 32'd0);
    $display("flush at T+10, busy=%b", busy32);
    run_op(0, F_DIVU, 32'd9, 32'd3, 33);

    // Reset pulse in the middle of a divide.
    Funct3 = F_DIV; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1; start32 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_result", res32, 32'd0);
    check_eq("midrst_busy", {31'd0, busy32}, 32'd0);
    check_eq("midrst_done", {31'd0, done32}, 32'd0);
    $display("reset mid-op, result=%h busy=%b done=%b", res32, busy32, done32);
    @(posedge clk); #1;

    try_bad(2'b10, 7'b0000000);
    try_bad(2'b00, 7'b0000001);

    run_op(1, F_DIV,  32'h0000_FFF9, 32'd2, 17);
    run_op(1, F_REM,  32'h0000_FFF9, 32'd2, 17);
    run_op(1, F_DIVU, 32'd100,       32'd7, 17);
    run_op(1, F_REMU, 32'd100,       32'd7, 17);

    repeat (5) @(negedge clk);
    check_eq("q32_drained", 32'(q32.size()), 32'd0);
    check_eq("q16_drained", 32'(q16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
